// File: rtl/dual_rail_pkg.sv
// Shared types, rail encodings and the per-bit code check for dual-rail (WDDL-style) logic.
package dual_rail_pkg;

    typedef enum logic {
        PH_PRE  = 1'b0,
        PH_EVAL = 1'b1
    } phase_e;

    localparam logic [1:0] RAIL_ONE    = 2'b10;
    localparam logic [1:0] RAIL_ZERO   = 2'b01;
    localparam logic [1:0] RAIL_SPACER = 2'b00;

    // True when the (t,f) pair carries a data value, i.e. is exactly one-hot.
    function automatic logic dr_valid_code(input logic t, input logic f);
        return ({t, f} == RAIL_ONE) || ({t, f} == RAIL_ZERO);
    endfunction

endpackage

// File: rtl/dual_rail_checker.sv
// Combinational rail-code checker for a WIDTH-bit dual-rail input word.
// Only instantiated when DUAL_RAIL_CHECK_EN is defined.
module dual_rail_checker
    import dual_rail_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  phase_e             phase_i,
    input  logic               in_valid_i,
    input  logic [WIDTH-1:0]   in_t_i,
    input  logic [WIDTH-1:0]   in_f_i,
    output logic               violation_o
);

    logic bad_code_s;
    logic violation_s;

    // Any non-one-hot bit in an evaluating word, or any active rail during precharge.
    always_comb begin
        bad_code_s  = 1'b0;
        violation_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            bad_code_s = bad_code_s | ~dr_valid_code(in_t_i[i], in_f_i[i]);
        end
        if (phase_i == PH_EVAL) begin
            violation_s = in_valid_i & bad_code_s;
        end else begin
            violation_s = |(in_t_i | in_f_i);
        end
    end

    assign violation_o = violation_s;

endmodule

// File: rtl/dual_rail_pipe_reg.sv
// Elastic dual-rail pipeline register with a global PRECHARGE/EVALUATE phase.
// Define DUAL_RAIL_CHECK_EN to add input rail checking with a sticky flag and saturating counter.
module dual_rail_pipe_reg
    import dual_rail_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int STAGES    = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 phase,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_t,
    input  logic [WIDTH-1:0]     in_f,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_t,
    output logic [WIDTH-1:0]     out_f,
    input  logic                 err_clr,
    output logic                 rail_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    phase_e             phase_q, phase_d;
    logic [STAGES-1:0]  valid_q, valid_d;
    logic [STAGES-1:0]  stage_rdy_s;
    logic [WIDTH-1:0]   t_q [STAGES];
    logic [WIDTH-1:0]   t_d [STAGES];
    logic [WIDTH-1:0]   f_q [STAGES];
    logic [WIDTH-1:0]   f_d [STAGES];
    logic               eval_s, advance_s, in_ready_s, accept_s, rdy_chain_s;

    assign eval_s     = (phase_q == PH_EVAL);
    assign advance_s  = ~valid_q[STAGES-1] | out_ready;
    assign in_ready_s = eval_s & (~valid_q[0] | advance_s);
    assign accept_s   = in_ready_s & in_valid;

    // Phase alternates every clock.
    always_comb begin
        phase_d = PH_PRE;
        case (phase_q)
            PH_PRE:  phase_d = PH_EVAL;
            PH_EVAL: phase_d = PH_PRE;
            default: phase_d = PH_PRE;
        endcase
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_PRE;
        end else begin
            phase_q <= phase_d;
        end
    end

    // A stage can take a new word when it is empty or its own word moves on.
    always_comb begin
        stage_rdy_s = {STAGES{1'b0}};
        rdy_chain_s = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy_chain_s    = ~valid_q[i] | rdy_chain_s;
            stage_rdy_s[i] = rdy_chain_s;
        end
    end

    // Elastic shift, applied only on the edge that closes an EVALUATE cycle.
    always_comb begin
        valid_d = valid_q;
        t_d     = t_q;
        f_d     = f_q;
        if (eval_s) begin
            if (stage_rdy_s[0]) begin
                valid_d[0] = accept_s;
                if (accept_s) begin
                    t_d[0] = in_t;
                    f_d[0] = in_f;
                end else begin
                    t_d[0] = t_q[0];
                    f_d[0] = f_q[0];
                end
            end else begin
                valid_d[0] = valid_q[0];
            end
            for (int i = 1; i < STAGES; i++) begin
                if (stage_rdy_s[i]) begin
                    valid_d[i] = valid_q[i-1];
                    t_d[i]     = t_q[i-1];
                    f_d[i]     = f_q[i-1];
                end else begin
                    valid_d[i] = valid_q[i];
                end
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                t_q[i] <= {WIDTH{1'b0}};
                f_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            t_q     <= t_d;
            f_q     <= f_d;
        end
    end

    assign phase     = eval_s;
    assign in_ready  = in_ready_s;
    assign out_valid = eval_s & valid_q[STAGES-1];
    assign out_t     = out_valid ? t_q[STAGES-1] : {WIDTH{1'b0}};
    assign out_f     = out_valid ? f_q[STAGES-1] : {WIDTH{1'b0}};

`ifdef DUAL_RAIL_CHECK_EN
    logic                 viol_s;
    logic                 rail_err_q, rail_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    dual_rail_checker #(.WIDTH(WIDTH)) u_checker (
        .phase_i     (phase_q),
        .in_valid_i  (in_valid),
        .in_t_i      (in_t),
        .in_f_i      (in_f),
        .violation_o (viol_s)
    );

    // Clear beats a simultaneous violation; the counter sticks at all-ones.
    always_comb begin
        rail_err_d = rail_err_q;
        err_cnt_d  = err_cnt_q;
        if (err_clr) begin
            rail_err_d = 1'b0;
            err_cnt_d  = {ERR_CNT_W{1'b0}};
        end else if (viol_s) begin
            rail_err_d = 1'b1;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            rail_err_d = rail_err_q;
        end
    end

    // Error status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rail_err_q <= 1'b0;
            err_cnt_q  <= {ERR_CNT_W{1'b0}};
        end else begin
            rail_err_q <= rail_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign rail_err = rail_err_q;
    assign err_cnt  = err_cnt_q;
`else
    logic unused_err_clr_s;
    assign unused_err_clr_s = err_clr;
    assign rail_err         = 1'b0;
    assign err_cnt          = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_dual_rail_pipe_reg.sv
// Scoreboard bench for dual_rail_pipe_reg; expectations follow DUAL_RAIL_CHECK_EN when it is defined.
module tb_dual_rail_pipe_reg;

`ifdef DUAL_RAIL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       phase, in_valid, in_ready, out_valid, out_ready, err_clr, rail_err;
    logic [3:0] in_t, in_f, out_t, out_f;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    dual_rail_pipe_reg #(.WIDTH(4), .STAGES(2), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .phase(phase),
        .in_valid(in_valid), .in_ready(in_ready), .in_t(in_t), .in_f(in_f),
        .out_valid(out_valid), .out_ready(out_ready), .out_t(out_t), .out_f(out_f),
        .err_clr(err_clr), .rail_err(rail_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: spacer in every PRE cycle, in-order words whenever a transfer happens.
    always @(negedge clk) begin
        if (!phase) begin
            chk("pre_spacer", {23'd0, out_valid, out_t, out_f}, 32'd0);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {24'd0, out_t, out_f}, 32'hFFFF_FFFF);
            end else begin
                chk("word_data", {24'd0, out_t, out_f}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [3:0] t, input logic [3:0] f);
        bit done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (phase) begin
                in_valid = 1'b1; in_t = t; in_f = f;
                if (in_ready) begin
                    done = 1'b1;
                    exp_q.push_back({t, f});
                end
                @(posedge clk); #1;
                in_valid = 1'b0; in_t = 4'h0; in_f = 4'h0;
            end
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pre_viol(input int n);
        repeat (n) begin
            @(negedge clk);
            if (phase) @(negedge clk);
            in_t = 4'h1;
            @(posedge clk); #1;
            in_t = 4'h0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_t = 4'h0; in_f = 4'h0; out_ready = 1'b1; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_phase", {31'd0, phase}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out", {23'd0, out_valid, out_t, out_f}, 32'd0);
        chk("rst_err", {23'd0, rail_err, err_cnt}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); chk("first_pre", {31'd0, phase}, 32'd0);
        @(negedge clk); chk("first_eval", {31'd0, phase}, 32'd1);

        // 1: latency and streaming
        send(4'hA, 4'h5);
        @(negedge clk); chk("lat_pre1", {31'd0, out_valid}, 32'd0);
        @(negedge clk); chk("lat_eval1", {31'd0, out_valid}, 32'd0);
        @(negedge clk); chk("lat_pre2", {31'd0, out_valid}, 32'd0);
        @(negedge clk); chk("lat_eval2", {31'd0, out_valid}, 32'd1);
        chk("lat_data", {28'd0, out_t}, 32'hA);
        send(4'h5, 4'hA);
        send(4'hA, 4'h5);
        repeat (8) @(negedge clk);
        chk("s1_drained", exp_q.size(), 32'd0);

        // 2/3: back-pressure, hold, simultaneous accept and emit
        @(posedge clk); #1 out_ready = 1'b0;
        send(4'hA, 4'h5);
        send(4'h5, 4'hA);
        repeat (4) begin
            @(negedge clk);
            if (phase) begin
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp_hold", {27'd0, out_valid, out_t}, 32'h1A);
            end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(4'h3, 4'hC);
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("occ_head", {27'd0, out_valid, out_t}, 32'h15);
        chk("occ_full", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("s2_drained", exp_q.size(), 32'd0);

        // 4/5: rail checking
        send(4'h1, 4'hF);
        @(negedge clk);
        chk("eval_viol_flag", {31'd0, rail_err}, {31'd0, CHK});
        chk("eval_viol_cnt", {24'd0, err_cnt}, CHK ? 32'd1 : 32'd0);
        pre_viol(1);
        @(negedge clk); chk("pre_viol_cnt", {24'd0, err_cnt}, CHK ? 32'd2 : 32'd0);
        pre_viol(252);
        @(negedge clk); chk("cnt_254", {24'd0, err_cnt}, CHK ? 32'hFE : 32'd0);
        pre_viol(1);
        @(negedge clk); chk("cnt_sat", {24'd0, err_cnt}, CHK ? 32'hFF : 32'd0);
        pre_viol(1);
        @(negedge clk); chk("cnt_sat_hold", {23'd0, rail_err, err_cnt}, CHK ? 32'h1FF : 32'd0);
        @(negedge clk);
        if (phase) @(negedge clk);
        in_t = 4'h1; err_clr = 1'b1;
        @(posedge clk); #1 in_t = 4'h0; err_clr = 1'b0;
        @(negedge clk); chk("clr_wins", {23'd0, rail_err, err_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        chk("clr_stays", {23'd0, rail_err, err_cnt}, 32'd0);
        chk("s4_drained", exp_q.size(), 32'd0);

        // 6: asynchronous reset with two words in flight
        @(posedge clk); #1 out_ready = 1'b0;
        send(4'h9, 4'h6);
        send(4'h6, 4'h9);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 8 && !seen; n++) begin
                @(negedge clk);
                if (phase && out_valid) seen = 1'b1;
            end
            chk("rst_pre_valid", {31'd0, seen}, 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", {23'd0, out_valid, out_t, out_f}, 32'd0);
        chk("async_rst_phase", {30'd0, phase, in_ready}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); chk("post_rst_pre", {31'd0, phase}, 32'd0);
        repeat (8) begin
            @(negedge clk);
            chk("no_stale", {31'd0, out_valid}, 32'd0);
        end

        chk("final_queue", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
